// File: rtl/rom_loader.sv
// Boot loader: consumes a byte stream (16-bit word count + little-endian words), writes the
// instruction ROM one word at a time and holds the core in reset until the image is complete.
module rom_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  // Widened by one bit so a full 16-bit count can be compared against 2**ADDR_W.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t      state, state_d;
  logic [15:0] cnt;
  logic [1:0]  byte_idx;
  logic [15:0] hdr_cnt;
  logic        accept;

  assign accept  = in_valid & in_ready;
  assign hdr_cnt = {in_data, cnt[7:0]};

  // NOTE: every combinational output gets a default first, otherwise an untaken branch
  // would make synthesis infer a latch to hold the old value.
  always_comb begin
    state_d = state;
    unique case (state)
      S_HDR0:  if (accept) state_d = S_HDR1;
      S_HDR1: begin
        if (accept) begin
          if (hdr_cnt == 16'd0)                state_d = S_DONE;
          else if ({1'b0, hdr_cnt} > DEPTH)    state_d = S_ERR;
          else                                 state_d = S_DATA;
        end
      end
      S_DATA:  if (accept && byte_idx == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = (cnt == 16'd1) ? S_DONE : S_DATA;
      S_DONE,
      S_ERR:   if (start) state_d = S_HDR0;
      default: state_d = S_HDR0;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HDR0;
      in_ready <= 1'b0;
      cnt      <= '0;
      byte_idx <= '0;
      rom_waddr <= '0;
      rom_wdata <= '0;
    end else begin
      state <= state_d;
      // Registered from the next state so ready never depends combinationally on in_*.
      in_ready <= (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
      unique case (state)
        S_HDR0: if (accept) cnt[7:0] <= in_data;
        S_HDR1: begin
          if (accept) begin
            cnt[15:8] <= in_data;
            rom_waddr <= '0;
            byte_idx  <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            rom_wdata[{byte_idx, 3'b000} +: 8] <= in_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          rom_waddr <= rom_waddr + 1'b1;
          cnt       <= cnt - 16'd1;
        end
        S_DONE,
        S_ERR: if (start) rom_waddr <= '0;
        default: ;
      endcase
    end
  end

  assign rom_we   = (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  assign cpu_hold = (state != S_DONE);

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: a driver streams images and queues the expected ROM
// writes; a monitor pops and compares every write as the loader issues it.
module tb_rom_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] img[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          writes   = 0;

  rom_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rom_we) begin
      writes++;
      check("ready_in_write", 32'(in_ready), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(rom_waddr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("waddr", 32'(rom_waddr), 32'(e.addr));
        check("wdata", rom_wdata, e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard = 0;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Streams header + img, queueing one expected write per word.
  task automatic load(input string tag, input int n, input bit stall);
    logic [31:0] w;
    send_byte(n[7:0], stall);
    send_byte(n[15:8], stall);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      sb.push_back('{addr: ADDR_W'(i), data: w});
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall);
    end
    wait_done(tag);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_test1();
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h0010_0093);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(rom_we), 32'd0);
    check("rst_waddr", 32'(rom_waddr), 32'd0);
    check("rst_wdata", rom_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Basic two-word image.
    set_test1();
    load("t1", 2, 1'b0);
    check("t1_writes", 32'(writes), 32'd2);

    // Bytes offered in DONE are not consumed.
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(negedge clk);
    check("done_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Restart from DONE, then a one-word reload.
    pulse_start();
    check("t6_hold", 32'(cpu_hold), 32'd1);
    check("t6_done", 32'(done), 32'd0);
    check("t6_waddr", 32'(rom_waddr), 32'd0);
    check("t6_ready", 32'(in_ready), 32'd1);
    img.delete();
    img.push_back(32'hDEAD_BEEF);
    load("t6", 1, 1'b0);

    // Zero-length image goes straight to DONE on the edge after the second header byte.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_hold", 32'(cpu_hold), 32'd0);

    // Random stalls must not lose or duplicate bytes.
    pulse_start();
    set_test1();
    load("t3", 2, 1'b1);

    // Oversized header: error, no writes, then recovery.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h10, 1'b0);
    check("t4_err", 32'(err), 32'd1);
    check("t4_hold", 32'(cpu_hold), 32'd1);
    check("t4_done", 32'(done), 32'd0);
    check("t4_ready", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("t4_err_held", 32'(err), 32'd1);
    pulse_start();
    check("t4_err_clr", 32'(err), 32'd0);
    check("t4_restart_ready", 32'(in_ready), 32'd1);
    load("t4", 2, 1'b0);

    // Reset mid-word discards the partial load.
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ready", 32'(in_ready), 32'd0);
    check("t5_rst_hold", 32'(cpu_hold), 32'd1);
    check("t5_rst_waddr", 32'(rom_waddr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    load("t5", 2, 1'b0);

    // Exactly full ROM: legal, last address wraps to 0.
    pulse_start();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back(32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000);
    load("full", DEPTH, 1'b0);
    check("full_wrap", 32'(rom_waddr), 32'd0);

    check("write_total", 32'(writes), 32'(9 + DEPTH));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
